dht11_emulator: RTL

DHT11_EMULATOR -- requirements
Module: dht11_emulator

---
 rtl/dht11_emulator.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/dht11_emulator.sv
// -----------------------------------------------------------------------------
// dht11_emulator
//   Emulates the sensor side of a DHT11 single-wire link. After a host
//   start-low of at least START_MIN_US the block answers with the DHT11
//   response preamble followed by a 40-bit frame {data_word, checksum}.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   dht_in      sampled level of the (externally pulled-up) data line
//   dht_oe      open-drain pull-low enable (1 = drive line low)
//   data_in     sensor word {hum_int, hum_dec, temp_int, temp_dec}
//   data_load   one-cycle strobe capturing data_in into the pending register
//   inject_err  (DHT11_EMU_CKSUM_ERR_EN only) flips checksum bit 0 when high
//               at response-delay entry
//   busy        high from start acceptance until frame completion
//   frame_done  one-cycle pulse when a frame completes
//
// Configuration
//   `define DHT11_EMU_CKSUM_ERR_EN to add the inject_err port.
// -----------------------------------------------------------------------------
module dht11_emulator #(
   parameter int unsigned CLK_FREQ     = 12000000,
   parameter int unsigned START_MIN_US = 18000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        dht_in,
   output logic        dht_oe,
   input  logic [31:0] data_in,
   input  logic        data_load,
`ifdef DHT11_EMU_CKSUM_ERR_EN
   input  logic        inject_err,
`endif
   output logic        busy,
   output logic        frame_done
);

   localparam int unsigned US_DIV = CLK_FREQ / 1000000;
   localparam int unsigned PW     = (US_DIV > 1) ? $clog2(US_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(US_DIV - 1);

   // Phase limits are stored as (duration - 1): a phase ends on the tick
   // that completes its last microsecond.
   localparam logic [15:0] LIM_START = 16'(START_MIN_US - 1);
   localparam logic [15:0] LIM_DLY   = 16'd29;
   localparam logic [15:0] LIM_RESP  = 16'd79;
   localparam logic [15:0] LIM_LOW   = 16'd49;
   localparam logic [15:0] LIM_ZERO  = 16'd25;
   localparam logic [15:0] LIM_ONE   = 16'd69;

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_START_LOW = 4'd1;
   localparam logic [3:0] S_WAIT_REL  = 4'd2;
   localparam logic [3:0] S_RESP_DLY  = 4'd3;
   localparam logic [3:0] S_RESP_LOW  = 4'd4;
   localparam logic [3:0] S_RESP_HIGH = 4'd5;
   localparam logic [3:0] S_BIT_LOW   = 4'd6;
   localparam logic [3:0] S_BIT_HIGH  = 4'd7;
   localparam logic [3:0] S_END_LOW   = 4'd8;

   logic [3:0]    state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [15:0]   us_q, us_d;
   logic [5:0]    bit_q, bit_d;
   logic [39:0]   shift_q, shift_d;
   logic [31:0]   pend_q, pend_d;
   logic          oe_q, oe_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          sync1_q, sync2_q;

   logic          tick;
   logic [7:0]    cksum;

   assign tick = (pre_q == PRE_MAX);

   always_comb begin
      cksum = pend_q[31:24] + pend_q[23:16] + pend_q[15:8] + pend_q[7:0];
`ifdef DHT11_EMU_CKSUM_ERR_EN
      cksum = cksum ^ {7'd0, inject_err};
`endif
   end

   // Two-flop synchronizer; resets to the idle (pulled-up) level so a reset
   // release never looks like a start request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= dht_in;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pend_d  = data_load ? data_in : pend_q;

      case (state_q)
         S_IDLE: begin
            if (!sync2_q) state_d = S_START_LOW;
         end
         S_START_LOW: begin
            if (sync2_q) begin
               state_d = S_IDLE;
            end else if (tick && us_q == LIM_START) begin
               state_d = S_WAIT_REL;
               busy_d  = 1'b1;
            end
         end
         S_WAIT_REL: begin
            if (sync2_q) begin
               state_d = S_RESP_DLY;
               shift_d = {pend_q, cksum};
               bit_d   = '0;
            end
         end
         S_RESP_DLY: begin
            if (tick && us_q == LIM_DLY) state_d = S_RESP_LOW;
         end
         S_RESP_LOW: begin
            if (tick && us_q == LIM_RESP) state_d = S_RESP_HIGH;
         end
         S_RESP_HIGH: begin
            if (tick && us_q == LIM_RESP) state_d = S_BIT_LOW;
         end
         S_BIT_LOW: begin
            if (tick && us_q == LIM_LOW) state_d = S_BIT_HIGH;
         end
         S_BIT_HIGH: begin
            // High time is chosen by the bit currently at the MSB.
            if (tick && us_q == (shift_q[39] ? LIM_ONE : LIM_ZERO)) begin
               shift_d = {shift_q[38:0], 1'b0};
               if (bit_q == 6'd39) begin
                  state_d = S_END_LOW;
               end else begin
                  state_d = S_BIT_LOW;
                  bit_d   = bit_q + 6'd1;
               end
            end
         end
         S_END_LOW: begin
            if (tick && us_q == LIM_LOW) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               bit_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Prescaler and us counter restart on every state change.
      if (state_d != state_q) begin
         pre_d = '0;
         us_d  = '0;
      end else if (tick) begin
         pre_d = '0;
         us_d  = us_q + 16'd1;
      end else begin
         pre_d = pre_q + PW'(1);
         us_d  = us_q;
      end

      oe_d = (state_d == S_RESP_LOW) || (state_d == S_BIT_LOW) ||
             (state_d == S_END_LOW);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         us_q    <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         pend_q  <= '0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         us_q    <= us_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         pend_q  <= pend_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign dht_oe     = oe_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule
